// File: rtl/mmio_uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : mmio_uart_pkg
// Brief   : Shared register offsets, STATUS layout and FSM encoding for the
//           MMIO UART transmitter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mmio_uart_pkg;

   // Register offsets, decoded from mmio_addr[3:2]
   localparam logic [1:0] c_reg_txdata = 2'd0;
   localparam logic [1:0] c_reg_status = 2'd1;

   // STATUS bit positions
   localparam int c_stat_busy      = 0;
   localparam int c_stat_full      = 1;
   localparam int c_stat_empty     = 2;
   localparam int c_stat_ovf       = 3;
   localparam int c_stat_count_lsb = 8;

   // Serializer FSM encoding
   localparam int         c_state_w   = 3;
   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_start  = 3'd1;
   localparam logic [2:0] c_st_data   = 3'd2;
   localparam logic [2:0] c_st_parity = 3'd3;
   localparam logic [2:0] c_st_stop   = 3'd4;

   function automatic logic [31:0] pack_status(input logic       busy,
                                               input logic       full,
                                               input logic       empty,
                                               input logic       ovf,
                                               input logic [8:0] count);
      logic [31:0] w_word;
      w_word                                  = 32'd0;
      w_word[c_stat_busy]                     = busy;
      w_word[c_stat_full]                     = full;
      w_word[c_stat_empty]                    = empty;
      w_word[c_stat_ovf]                      = ovf;
      w_word[c_stat_count_lsb +: 9]           = count;
      return w_word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : sync_fifo
// Brief   : Single-clock FIFO; a push while full is accepted when a pop
//           happens at the same edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge sys_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
//------------------------------------------------------------------------------
// Module  : mmio_uart_tx
// Brief   : MMIO-programmed UART transmitter with TX FIFO and STATUS register.
//           Define MMIO_UART_TX_PARITY_EN to add an even-parity bit per frame.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        mmio_read,
   input  logic        mmio_write,
   input  logic [31:0] mmio_addr,
   input  logic [31:0] mmio_write_data,
   output logic        mmio_done,
   output logic [31:0] mmio_read_data,
   output logic        uart_tx_pin
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                 w_full;
   logic                 w_empty;
   logic [CNT_W-1:0]     w_count;
   logic [7:0]           w_head;
   logic                 w_push;
   logic                 w_pop;

   logic                 r_done;
   logic [31:0]          r_rdata;
   logic                 r_ovf;
   logic                 r_stalled;
   logic                 w_req;
   logic [1:0]           w_off;
   logic                 w_wr_txdata;
   logic                 w_wr_stall;
   logic                 w_complete;
   logic                 w_rd_status;
   logic [31:0]          w_status;
   logic                 w_unused;

   logic [c_state_w-1:0] r_state;
   logic [c_state_w-1:0] w_state_next;
   logic [15:0]          r_baud;
   logic [2:0]           r_bit;
   logic [7:0]           r_byte;
   logic                 r_pin;
   logic                 w_bit_end;
   logic [2:0]           w_bit_next;
   logic                 w_pin_next;
   logic                 w_busy;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .push    (w_push),
      .pop     (w_pop),
      .din     (mmio_write_data[7:0]),
      .dout    (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   // MMIO decode: a full-FIFO write stalls until the serializer frees a slot.
   assign w_req       = !r_done && (mmio_read || mmio_write);
   assign w_off       = mmio_addr[3:2];
   assign w_wr_txdata = w_req && mmio_write && (w_off == c_reg_txdata);
   assign w_wr_stall  = w_wr_txdata && w_full && !w_pop;
   assign w_push      = w_wr_txdata && !w_wr_stall;
   assign w_complete  = w_req && !w_wr_stall;
   assign w_rd_status = w_complete && !mmio_write && (w_off == c_reg_status);
   assign w_status    = pack_status(w_busy, w_full, w_empty, r_ovf, 9'(w_count));
   assign w_unused    = ^{mmio_addr[31:4], mmio_addr[1:0], mmio_write_data[31:8]};

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_done    <= 1'b0;
         r_rdata   <= 32'd0;
         r_ovf     <= 1'b0;
         r_stalled <= 1'b0;
      end else begin
         r_done    <= w_complete;
         r_rdata   <= w_rd_status ? w_status : 32'd0;
         r_stalled <= w_wr_stall;
         if (w_wr_stall && !r_stalled) r_ovf <= 1'b1;
         else if (w_rd_status)         r_ovf <= 1'b0;
      end
   end

   assign mmio_done      = r_done;
   assign mmio_read_data = r_rdata;
   assign uart_tx_pin    = r_pin;

   assign w_bit_end  = (r_baud == 16'(CLKS_PER_BIT - 1));
   assign w_bit_next = (r_state == c_st_data && w_bit_end) ? r_bit + 1'b1 : r_bit;

   // State register and serializer datapath
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_baud  <= 16'd0;
         r_bit   <= 3'd0;
         r_byte  <= 8'd0;
         r_pin   <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_baud  <= (r_state == c_st_idle || w_bit_end) ? 16'd0 : r_baud + 16'd1;
         r_bit   <= w_bit_next;
         if (w_pop) r_byte <= w_head;
         r_pin   <= w_pin_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (!w_empty) w_state_next = c_st_start;
         end
         c_st_start: begin
            if (w_bit_end) w_state_next = c_st_data;
         end
         c_st_data: begin
            if (w_bit_end && r_bit == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
               w_state_next = c_st_parity;
`else
               w_state_next = c_st_stop;
`endif
            end
         end
`ifdef MMIO_UART_TX_PARITY_EN
         c_st_parity: begin
            if (w_bit_end) w_state_next = c_st_stop;
         end
`endif
         c_st_stop: begin
            if (w_bit_end) w_state_next = w_empty ? c_st_idle : c_st_start;
         end
         default: w_state_next = c_st_idle;
      endcase
   end

   // Outputs: pin value is computed for the state being entered so it
   // changes on the same edge as the state.
   always_comb begin
      w_busy     = (r_state != c_st_idle);
      w_pop      = !w_empty &&
                   ((r_state == c_st_idle) || (r_state == c_st_stop && w_bit_end));
      w_pin_next = 1'b1;
      case (w_state_next)
         c_st_start:  w_pin_next = 1'b0;
         c_st_data:   w_pin_next = r_byte[w_bit_next];
`ifdef MMIO_UART_TX_PARITY_EN
         c_st_parity: w_pin_next = ^r_byte;
`endif
         default:     w_pin_next = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, sys_clk cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries (power of two, 2..256).
REQ-003 SHALL have port sys_clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mmio_read  input  1  read request, held high until mmio_done.
REQ-006 SHALL have port mmio_write  input  1  write request, held high until mmio_done.
REQ-007 SHALL have port mmio_addr  input  32  byte address; only bits [3:2] decoded.
REQ-008 SHALL have port mmio_write_data  input  32  write payload.
REQ-009 SHALL have port mmio_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mmio_read_data  output  32  read payload, valid while mmio_done high.
REQ-011 SHALL have port uart_tx_pin  output  1  serial line, idle high, registered.

Function
REQ-012 Register map: offset 0x0 TXDATA (write: push mmio_write_data[7:0]; read: 0); offset 0x4 STATUS (read only: bit0 busy = FSM not IDLE, bit1 full, bit2 empty, bit3 overflow_sticky, bits[16:8] count); other offsets read 0, writes ignored, both still complete.
REQ-013 Request sampled at edge E with mmio_done low: read/STATUS/undefined complete with mmio_done high in cycle after E; request ignored while mmio_done high.
REQ-014 TXDATA write when FIFO not full: byte pushed at E, mmio_done high cycle after E.
REQ-015 TXDATA write when FIFO full: mmio_done withheld, push and done occur at first edge at which space exists (pop at same edge counts as space); overflow_sticky set when a write is first sampled full.
REQ-016 overflow_sticky cleared only by a STATUS read (cleared at the completing edge; the completing read returns 1).
REQ-017 mmio_read and mmio_write both high: treated as write.
REQ-018 FSM states IDLE, START, DATA, PARITY, STOP; IDLE with FIFO nonempty pops head and enters START at next edge, uart_tx_pin low at that edge.
REQ-019 Each state bit lasts exactly CLKS_PER_BIT cycles; DATA sends 8 bits LSB first with 3-bit index; STOP drives 1.
REQ-020 STOP end: FIFO nonempty -> START directly (no idle gap); else IDLE.
REQ-021 Simultaneous push and pop: count unchanged, both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-022 count width clog2(FIFO_DEPTH)+1, saturates never exceeding FIFO_DEPTH.

Reset
REQ-023 rst_n low at an edge: FIFO emptied, overflow_sticky 0, FSM IDLE, bit counters 0, uart_tx_pin 1, mmio_done 0, mmio_read_data 0.
REQ-024 Reset mid-frame aborts frame; pin high next edge; no partial byte resumes.

Configuration
REQ-025 Macro MMIO_UART_TX_PARITY_EN defined: PARITY state inserted after DATA, sending even parity (XOR of 8 data bits), frame 11 bits.
REQ-026 Macro undefined: PARITY state and logic absent, DATA -> STOP, frame 10 bits.

Structure
REQ-027 Shared package mmio_uart_pkg SHALL hold register offsets, STATUS bit positions, FSM state encoding.
REQ-028 FIFO SHALL be sub-module sync_fifo (push, pop, din, dout, full, empty, count); serializer FSM and MMIO decode in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Write 0x55 to 0x0 -> done 1 cycle later; pin low 2 edges after sample; bits 1,0,1,0,1,0,1,0 each 4 cycles; stop high; 40 cycles frame (44 with parity, parity 0).
REQ-030 Write 0xA5, 0x3C back-to-back -> STOP of first frame followed immediately by START of second, no idle cycles.
REQ-031 Hold FSM busy, write 5 bytes -> 5th write's done delayed until first pop; STATUS read returns bit3=1, next STATUS read bit3=0.
REQ-032 Read 0x4 when idle/empty -> mmio_read_data 0x00000004, done one cycle after sample; read 0x8 -> 0.
REQ-033 Assert rst_n low during DATA of 0xFF -> next edge pin 1, STATUS 0x00000004, no further frame.
REQ-034 Read and write both high to 0x0 with data 0x41 -> treated as write; 0x41 transmitted.
